// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: one-hot selected bus multiplexer feeding a one-entry
// valid/ready output buffer, with a handshake counter and registered
// address pass-through paths.
// Optional build macro BUS_PARITY_EN adds a data_par output carrying the
// even parity (XOR) of the word held in data_out.
module bus_mux_pipe #(
    parameter int DATA_W = 16,
    parameter int N_SRC  = 8,
    parameter int ADDR_W = 16,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC-1:0]          sel,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          src_idx,
    output logic                      sel_err,
    output logic [15:0]               xfer_cnt,
    input  logic [ADDR_W-1:0]         ar_in,
    input  logic [ADDR_W-1:0]         pc_in,
    output logic [ADDR_W-1:0]         addr,
`ifdef BUS_PARITY_EN
    output logic [ADDR_W-1:0]         pc_addr,
    output logic                      data_par
`else
    output logic [ADDR_W-1:0]         pc_addr
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [15:0]         xfer_q, xfer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   pc_addr_q, pc_addr_d;
`ifdef BUS_PARITY_EN
    logic                par_q, par_d;
`endif

    // Each source gated by its own select bit; OR of these is the mux output
    // when sel is one-hot.
    logic [DATA_W-1:0]   masked [N_SRC];
    logic [DATA_W-1:0]   data_sel;
    logic [IDX_W-1:0]    idx_sel;
    logic                sel_onehot;
    logic [DATA_W-1:0]   word_cap;
    logic                accept;
    logic                handshake;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
            assign masked[gi] = src_data[gi*DATA_W +: DATA_W] & {DATA_W{sel[gi]}};
        end
    endgenerate

    // AND-OR mux plus binary encode of the select; only meaningful when one-hot.
    always_comb begin
        data_sel = '0;
        idx_sel  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            data_sel = data_sel | masked[k];
            if (sel[k]) begin
                idx_sel = idx_sel | IDX_W'(k);
            end
        end
    end

    // A select is legal only with exactly one bit set; zero and multi-hot
    // selects still produce a beat, but as a zero word flagged by sel_err.
    assign sel_onehot = (sel != '0) && ((sel & (sel - N_SRC'(1))) == '0);
    assign word_cap   = sel_onehot ? data_sel : '0;

    assign out_valid  = (state_q == FULL);
    assign sel_ready  = !out_valid || out_ready;
    assign accept     = sel_valid && sel_ready;
    assign handshake  = out_valid && out_ready;

    // Next-state and capture logic for the one-entry buffer; a simultaneous
    // drain and accept keeps the buffer FULL with the new beat.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        err_d     = err_q;
        xfer_d    = xfer_q;
        addr_d    = ar_in;
        pc_addr_d = pc_in;
`ifdef BUS_PARITY_EN
        par_d     = par_q;
`endif
        if (accept) begin
            state_d = FULL;
            data_d  = word_cap;
            idx_d   = sel_onehot ? idx_sel : '0;
            err_d   = !sel_onehot;
`ifdef BUS_PARITY_EN
            par_d   = ^word_cap;
`endif
        end else if (handshake) begin
            state_d = EMPTY;
        end
        if (handshake) begin
            xfer_d = xfer_q + 16'd1;
        end
    end

    // State registers; reset clears everything immediately, dropping any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            xfer_q    <= '0;
            addr_q    <= '0;
            pc_addr_q <= '0;
`ifdef BUS_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            xfer_q    <= xfer_d;
            addr_q    <= addr_d;
            pc_addr_q <= pc_addr_d;
`ifdef BUS_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign data_out = data_q;
    assign src_idx  = idx_q;
    assign sel_err  = err_q;
    assign xfer_cnt = xfer_q;
    assign addr     = addr_q;
    assign pc_addr  = pc_addr_q;
`ifdef BUS_PARITY_EN
    assign data_par = par_q;
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Directed testbench for bus_mux_pipe (default parameters).
// Define BUS_PARITY_EN for both files to also exercise data_par.
module tb_bus_mux_pipe;

    localparam int DATA_W = 16;
    localparam int N_SRC  = 8;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 3;

    logic                     clk;
    logic                     rst_n;
    logic [N_SRC*DATA_W-1:0]  src_data;
    logic [N_SRC-1:0]         sel;
    logic                     sel_valid;
    logic                     sel_ready;
    logic [DATA_W-1:0]        data_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         src_idx;
    logic                     sel_err;
    logic [15:0]              xfer_cnt;
    logic [ADDR_W-1:0]        ar_in;
    logic [ADDR_W-1:0]        pc_in;
    logic [ADDR_W-1:0]        addr;
    logic [ADDR_W-1:0]        pc_addr;
`ifdef BUS_PARITY_EN
    logic                     data_par;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    bus_mux_pipe #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .src_idx   (src_idx),
        .sel_err   (sel_err),
        .xfer_cnt  (xfer_cnt),
        .ar_in     (ar_in),
        .pc_in     (pc_in),
        .addr      (addr),
`ifdef BUS_PARITY_EN
        .pc_addr   (pc_addr),
        .data_par  (data_par)
`else
        .pc_addr   (pc_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [DATA_W-1:0] v);
        src_data[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic [DATA_W-1:0] src_val(input int k);
        // Hand-chosen distinct source words: src k = 0x1111*k + 0x0102
        return DATA_W'(32'h1111 * k + 32'h0102);
    endfunction

    initial begin
        rst_n     = 1'b0;
        sel       = '0;
        sel_valid = 1'b0;
        out_ready = 1'b0;
        ar_in     = '0;
        pc_in     = '0;
        src_data  = '0;
        for (int k = 0; k < N_SRC; k++) set_src(k, src_val(k));
        set_src(2, 16'hA5A5);

        // ---- reset state ----
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        check("rst_sel_ready", 32'(sel_ready), 32'd1);
        check("rst_addr",      32'(addr),      32'd0);
`ifdef BUS_PARITY_EN
        check("rst_data_par",  32'(data_par),  32'd0);
`endif

        // ---- basic one-hot capture, latency 1 ----
        rst_n     = 1'b1;
        sel       = 8'h04;
        sel_valid = 1'b1;
        out_ready = 1'b1;
        ar_in     = 16'h1234;
        pc_in     = 16'h5678;
        step();
        check("cap_data_out",  32'(data_out),  32'hA5A5);
        check("cap_src_idx",   32'(src_idx),   32'd2);
        check("cap_out_valid", 32'(out_valid), 32'd1);
        check("cap_sel_err",   32'(sel_err),   32'd0);
        check("cap_addr",      32'(addr),      32'h1234);
        check("cap_pc_addr",   32'(pc_addr),   32'h5678);
        check("cap_xfer_cnt",  32'(xfer_cnt),  32'd0);

        // ---- illegal selects: multi-hot then zero ----
        sel = 8'h06;
        step();
        check("mh_data_out",  32'(data_out),  32'd0);
        check("mh_sel_err",   32'(sel_err),   32'd1);
        check("mh_out_valid", 32'(out_valid), 32'd1);
        check("mh_src_idx",   32'(src_idx),   32'd0);
        check("mh_xfer_cnt",  32'(xfer_cnt),  32'd1);
        sel = 8'h00;
        step();
        check("zh_data_out",  32'(data_out),  32'd0);
        check("zh_sel_err",   32'(sel_err),   32'd1);
        check("zh_out_valid", 32'(out_valid), 32'd1);
        check("zh_xfer_cnt",  32'(xfer_cnt),  32'd2);

        // ---- capture source 3, then stall for 5 cycles ----
        sel = 8'h08;
        step();
        check("pre_stall_data", 32'(data_out), 32'(src_val(3)));
        check("pre_stall_idx",  32'(src_idx),  32'd3);
        check("pre_stall_err",  32'(sel_err),  32'd0);
        check("pre_stall_xfer", 32'(xfer_cnt), 32'd3);
        out_ready = 1'b0;
        #1;
        check("stall_sel_ready0", 32'(sel_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            sel = (i % 2 == 0) ? 8'h40 : 8'h03;
            set_src(3, 16'hDEAD + 16'(i));
            step();
            check("stall_data_out",  32'(data_out),  32'(src_val(3)));
            check("stall_src_idx",   32'(src_idx),   32'd3);
            check("stall_sel_err",   32'(sel_err),   32'd0);
            check("stall_sel_ready", 32'(sel_ready), 32'd0);
            check("stall_xfer_cnt",  32'(xfer_cnt),  32'd3);
        end
        set_src(3, src_val(3));

        // ---- drain ----
        sel_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_xfer_cnt",  32'(xfer_cnt),  32'd4);
        check("drain_sel_ready", 32'(sel_ready), 32'd1);

        // ---- 10 back-to-back beats walking sel ----
        sel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = 8'(1 << (i % 8));
            step();
            check("walk_out_valid", 32'(out_valid), 32'd1);
            check("walk_data_out",  32'(data_out),  32'(((i % 8) == 2) ? 16'hA5A5 : src_val(i % 8)));
            check("walk_src_idx",   32'(src_idx),   32'(i % 8));
            check("walk_xfer_cnt",  32'(xfer_cnt),  32'(4 + i));
        end
        sel_valid = 1'b0;
        step();
        check("walk_final_xfer", 32'(xfer_cnt), 32'd14);
        check("walk_final_vld",  32'(out_valid), 32'd0);

        // ---- asynchronous reset while FULL ----
        sel_valid = 1'b1;
        sel       = 8'h01;
        ar_in     = 16'hBEEF;
        pc_in     = 16'hCAFE;
        step();
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        sel_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_data_out",  32'(data_out),  32'd0);
        check("arst_src_idx",   32'(src_idx),   32'd0);
        check("arst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        check("arst_addr",      32'(addr),      32'd0);
        check("arst_pc_addr",   32'(pc_addr),   32'd0);
        #1;
        rst_n = 1'b1;

        // ---- counter wrap: continuous handshakes ----
        sel_valid = 1'b1;
        out_ready = 1'b1;
        sel       = 8'h02;
        step();
        check("wrap_start_xfer", 32'(xfer_cnt), 32'd0);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_ffff", 32'(xfer_cnt), 32'hFFFF);
        step();
        check("wrap_zero", 32'(xfer_cnt), 32'h0000);

`ifdef BUS_PARITY_EN
        // ---- parity ----
        set_src(5, 16'h0007);
        set_src(6, 16'h0003);
        sel = 8'h20;
        step();
        check("par_0007", 32'(data_par), 32'd1);
        sel = 8'h40;
        step();
        check("par_0003", 32'(data_par), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_mux_pipe.md
BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

Interface
REQ-001 Parameter DATA_W, default 16, width of each source word and of data_out.
REQ-002 Parameter N_SRC, default 8, number of bus sources; legal range 2..32.
REQ-003 Parameter ADDR_W, default 16, width of address pass-through paths.
REQ-004 Localparam IDX_W = $clog2(N_SRC).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 src_data  input  N_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-008 sel  input  N_SRC  one-hot source select.
REQ-009 sel_valid  input  1  request to transfer selected source.
REQ-010 sel_ready  output  1  block can accept a request this cycle.
REQ-011 data_out  output  DATA_W  registered bus word.
REQ-012 out_valid  output  1  data_out holds an unconsumed beat.
REQ-013 out_ready  input  1  consumer accepts data_out.
REQ-014 src_idx  output  IDX_W  binary index of source captured in current beat.
REQ-015 sel_err  output  1  current beat was captured with illegal sel.
REQ-016 xfer_cnt  output  16  count of completed output handshakes.
REQ-017 ar_in, pc_in  input  ADDR_W  address sources.
REQ-018 addr, pc_addr  output  ADDR_W  registered copies of ar_in, pc_in.

Function
REQ-019 Output stage SHALL be a one-entry buffer with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 sel_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-021 Accept SHALL occur when sel_valid && sel_ready; capture on that edge, out_valid=1 next cycle (latency 1).
REQ-022 On accept with sel one-hot at bit k: data_out <= source k, src_idx <= k, sel_err <= 0.
REQ-023 On accept with sel zero or multi-hot: data_out <= 0, src_idx <= 0, sel_err <= 1; beat still delivered.
REQ-024 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL stays FULL on simultaneous out_ready and accept (back-to-back, no bubble).
REQ-025 FULL && !out_ready: data_out, src_idx, sel_err SHALL hold; sel_ready=0; sel/src_data changes ignored.
REQ-026 Handshake out_valid && out_ready SHALL increment xfer_cnt by 1 on that edge; 0xFFFF wraps to 0x0000.
REQ-027 addr <= ar_in and pc_addr <= pc_in every cycle, independent of handshake state.
REQ-028 sel_valid while sel_ready=0 SHALL have no effect; requester must hold request.

Reset
REQ-029 rst_n low SHALL immediately force: out_valid=0, data_out=0, src_idx=0, sel_err=0, xfer_cnt=0, addr=0, pc_addr=0.
REQ-030 Reset mid-transfer SHALL discard the held beat; first accept allowed on first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro BUS_PARITY_EN defined: output data_par (1 bit) SHALL be registered with data_out as XOR of the captured word (even parity), 0 in reset, held under stall.
REQ-032 Macro BUS_PARITY_EN undefined: data_par port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset then sel=8'h04, src2=16'hA5A5, sel_valid=1, out_ready=1 -> next cycle data_out=16'hA5A5, src_idx=2, out_valid=1, sel_err=0.
REQ-034 sel=8'h06 accepted -> data_out=0, sel_err=1, out_valid=1; sel=8'h00 likewise.
REQ-035 FULL with out_ready=0 for 5 cycles while sel toggles -> data_out stable, sel_ready=0, xfer_cnt unchanged.
REQ-036 Continuous sel_valid=1, out_ready=1 for 10 cycles walking sel -> one beat per cycle, xfer_cnt=10; preload 0xFFFF-boundary run -> wraps to 0.
REQ-037 rst_n asserted asynchronously between edges while FULL -> out_valid and all outputs 0 before next edge.
REQ-038 BUS_PARITY_EN defined, word 16'h0007 captured -> data_par=1; word 16'h0003 -> data_par=0.
